// File: rtl/fyra_pkg.sv
// Shared types and constants for the fyra core's load/store unit.
// Memory op encodings match the decoder's memCtrl field.
package fyra_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_LBU = 3'b011,
        OP_LHU = 3'b100,
        OP_SB  = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } lsu_state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Encodings 000..100 are loads, 101..111 are stores.
    function automatic logic is_load_op(input mem_op_e op);
        return (op <= OP_LHU);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the LSU: request side builds byte enables and replicated
// store data, response side extracts and extends load data.
module lsu_lane_align
    import fyra_pkg::*;
(
    input  logic [1:0]  req_lane_i,
    input  mem_op_e     req_op_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o,
    input  logic [1:0]  rsp_lane_i,
    input  mem_op_e     rsp_op_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] rdata_ext_o
);

    logic [7:0]  rspByte;
    logic [15:0] rspHalf;

    always_comb begin
        be_o         = BE_WORD;
        wdata_o      = wdata_i;
        misaligned_o = 1'b0;
        case (req_op_i)
            OP_LB, OP_LBU, OP_SB: begin
                be_o    = BE_BYTE << req_lane_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                be_o         = BE_HALF << {req_lane_i[1], 1'b0};
                wdata_o      = {2{wdata_i[15:0]}};
                misaligned_o = req_lane_i[0];
            end
            default: begin
                be_o         = BE_WORD;
                wdata_o      = wdata_i;
                misaligned_o = |req_lane_i;
            end
        endcase
    end

    always_comb begin
        rspByte     = rdata_i[{rsp_lane_i, 3'b000} +: 8];
        rspHalf     = rdata_i[{rsp_lane_i[1], 4'b0000} +: 16];
        rdata_ext_o = rdata_i;
        case (rsp_op_i)
            OP_LB:   rdata_ext_o = {{24{rspByte[7]}}, rspByte};
            OP_LBU:  rdata_ext_o = {24'h0, rspByte};
            OP_LH:   rdata_ext_o = {{16{rspHalf[15]}}, rspHalf};
            OP_LHU:  rdata_ext_o = {16'h0, rspHalf};
            default: rdata_ext_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// MEM-stage load/store sequencer: one access per instruction onto a single-outstanding
// req/ack bus, with pipeline stall, alignment checking and an optional ack timeout.
module lsu_mem_sequencer
    import fyra_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic            mem_rd_i,
    input  logic            mem_wr_i,
    input  logic [2:0]      mem_ctrl_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            err_o,
    output logic            bus_req_o,
    output logic            bus_we_o,
    output logic [XLEN-1:0] bus_addr_o,
    output logic [3:0]      bus_be_o,
    output logic [XLEN-1:0] bus_wdata_o,
    input  logic            bus_ack_i,
    input  logic [XLEN-1:0] bus_rdata_i
);

    lsu_state_e      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    mem_op_e         op_q, op_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    mem_op_e         reqOp;
    logic            start;
    logic            illegal;
    logic            misaligned;
    logic [3:0]      reqBe;
    logic [XLEN-1:0] reqWdata;
    logic [XLEN-1:0] rdataExt;
    logic            timeoutHit;
    logic            busy;

    assign reqOp = mem_op_e'(mem_ctrl_i);
    assign start = valid_i & (mem_rd_i | mem_wr_i);
    assign busy  = (state_q == BUSY);

    // A load must carry a load encoding and a store a store encoding.
    assign illegal = (mem_rd_i & mem_wr_i)
                   | (mem_rd_i & ~is_load_op(reqOp))
                   | (mem_wr_i &  is_load_op(reqOp));

    lsu_lane_align u_lane_align (
        .req_lane_i   (addr_i[1:0]),
        .req_op_i     (reqOp),
        .wdata_i      (wdata_i),
        .be_o         (reqBe),
        .wdata_o      (reqWdata),
        .misaligned_o (misaligned),
        .rsp_lane_i   (addr_q[1:0]),
        .rsp_op_i     (op_q),
        .rdata_i      (bus_rdata_i),
        .rdata_ext_o  (rdataExt)
    );

    generate
        if (TIMEOUT != 0) begin : g_timeout
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] tcnt_q, tcnt_d;

            // Counter is held at zero outside BUSY, so entering BUSY always starts from 0.
            assign tcnt_d     = busy ? tcnt_q + 1'b1 : '0;
            assign timeoutHit = busy && (tcnt_q == CW'(TIMEOUT - 1));

            always_ff @(posedge clk) begin
                if (rst) tcnt_q <= '0;
                else     tcnt_q <= tcnt_d;
            end
        end else begin : g_no_timeout
            assign timeoutHit = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        op_d    = op_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    stall_o = 1'b1;
                    if (illegal || misaligned) begin
                        state_d = ERR;
                    end else begin
                        state_d = BUSY;
                        addr_d  = addr_i;
                        op_d    = reqOp;
                        be_d    = reqBe;
                        we_d    = mem_wr_i;
                        wdata_d = mem_wr_i ? reqWdata : '0;
                    end
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (bus_ack_i) begin
                    state_d = DONE;
                    rdata_d = we_q ? '0 : rdataExt;
                end else if (timeoutHit) begin
                    state_d = ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            op_q    <= OP_LB;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    // Bus outputs are quiet outside BUSY so an abandoned or finished access leaves nothing driven.
    assign bus_req_o   = busy;
    assign bus_we_o    = busy & we_q;
    assign bus_addr_o  = busy ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign bus_be_o    = busy ? be_q : 4'b0000;
    assign bus_wdata_o = busy ? wdata_q : '0;
    assign done_o      = (state_q == DONE);
    assign err_o       = (state_q == ERR);
    assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Directed self-checking bench for lsu_mem_sequencer (instantiated with TIMEOUT=4).
module tb_lsu_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, mem_rd_i, mem_wr_i;
    logic [2:0]  mem_ctrl_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, done_o, err_o;
    logic [31:0] rdata_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    int testsRun    = 0;
    int testsFailed = 0;

    lsu_mem_sequencer #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .mem_ctrl_i(mem_ctrl_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns after that.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic applyIdle();
        valid_i = 1'b0; mem_rd_i = 1'b0; mem_wr_i = 1'b0; mem_ctrl_i = 3'b000;
        addr_i = 32'h0; wdata_i = 32'h0;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] ctrl,
                                 input logic [31:0] addr, input logic [31:0] wd);
        valid_i = 1'b1; mem_rd_i = rd; mem_wr_i = wr; mem_ctrl_i = ctrl;
        addr_i = addr; wdata_i = wd;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        applyIdle();
        tick(); tick();
        settle();
        testsRun++; if (stall_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_stall got %0b want 0", stall_o); end
        testsRun++; if (done_o !== 1'b0 || err_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done_err got %0b%0b want 00", done_o, err_o); end
        testsRun++; if (bus_req_o !== 1'b0 || bus_we_o !== 1'b0 || bus_be_o !== 4'h0) begin testsFailed++; $display("[TB] FAIL reset_bus_ctl got req=%0b we=%0b be=%b want 0", bus_req_o, bus_we_o, bus_be_o); end
        testsRun++; if (bus_addr_o !== 32'h0 || bus_wdata_o !== 32'h0 || rdata_o !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_data got addr=%h wd=%h rd=%h want 0", bus_addr_o, bus_wdata_o, rdata_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lw_basic();
        int stallCount = 0;
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
        settle();
        stallCount += int'(stall_o);
        testsRun++; if (bus_req_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL lw_req_start got %0b want 0", bus_req_o); end
        tick(); settle();
        stallCount += int'(stall_o);
        testsRun++; if (bus_req_o !== 1'b1 || bus_we_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL lw_req_busy got req=%0b we=%0b want 1/0", bus_req_o, bus_we_o); end
        testsRun++; if (bus_addr_o !== 32'h0000_0100 || bus_be_o !== 4'b1111) begin testsFailed++; $display("[TB] FAIL lw_addr_be got %h/%b want 00000100/1111", bus_addr_o, bus_be_o); end
        tick(); settle();
        stallCount += int'(stall_o);
        tick();
        bus_ack_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF;
        settle();
        stallCount += int'(stall_o);
        testsRun++; if (done_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL lw_done_early got %0b want 0", done_o); end
        tick();
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        settle();
        stallCount += int'(stall_o);
        testsRun++; if (done_o !== 1'b1 || err_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL lw_done got done=%0b err=%0b want 1/0", done_o, err_o); end
        testsRun++; if (rdata_o !== 32'hDEAD_BEEF) begin testsFailed++; $display("[TB] FAIL lw_rdata got %h want deadbeef", rdata_o); end
        testsRun++; if (bus_req_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL lw_req_done got %0b want 0", bus_req_o); end
        testsRun++; if (stallCount !== 4) begin testsFailed++; $display("[TB] FAIL lw_stall_cycles got %0d want 4", stallCount); end
        tick();
        applyIdle();
        settle();
        testsRun++; if (done_o !== 1'b0 || rdata_o !== 32'hDEAD_BEEF) begin testsFailed++; $display("[TB] FAIL lw_hold got done=%0b rdata=%h want 0/deadbeef", done_o, rdata_o); end
    endtask

    task automatic test_byte_loads();
        logic [2:0] ops [2] = '{3'b000, 3'b011};
        logic [31:0] want [2] = '{32'hFFFF_FF80, 32'h0000_0080};
        for (int i = 0; i < 2; i++) begin
            tick();
            applyStimulus(1'b1, 1'b0, ops[i], 32'h0000_0103, 32'h0);
            tick();
            bus_ack_i = 1'b1; bus_rdata_i = 32'h80FF_FFFF;
            settle();
            testsRun++; if (bus_be_o !== 4'b1000 || bus_addr_o !== 32'h0000_0100) begin testsFailed++; $display("[TB] FAIL lb_be_%0d got %b/%h want 1000/00000100", i, bus_be_o, bus_addr_o); end
            tick();
            bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
            settle();
            testsRun++; if (done_o !== 1'b1 || rdata_o !== want[i]) begin testsFailed++; $display("[TB] FAIL lb_rdata_%0d got done=%0b rdata=%h want 1/%h", i, done_o, rdata_o, want[i]); end
            tick();
            applyIdle();
        end
    endtask

    task automatic test_store_half();
        tick();
        applyStimulus(1'b0, 1'b1, 3'b110, 32'h0000_0022, 32'h1234_ABCD);
        tick();
        bus_ack_i = 1'b1;
        settle();
        testsRun++; if (bus_be_o !== 4'b1100 || bus_we_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL sh_be_we got %b/%0b want 1100/1", bus_be_o, bus_we_o); end
        testsRun++; if (bus_wdata_o !== 32'hABCD_ABCD || bus_addr_o !== 32'h0000_0020) begin testsFailed++; $display("[TB] FAIL sh_wdata got %h/%h want abcdabcd/00000020", bus_wdata_o, bus_addr_o); end
        tick();
        bus_ack_i = 1'b0;
        settle();
        testsRun++; if (done_o !== 1'b1 || err_o !== 1'b0 || rdata_o !== 32'h0) begin testsFailed++; $display("[TB] FAIL sh_done got done=%0b err=%0b rdata=%h want 1/0/0", done_o, err_o, rdata_o); end
        tick();
        applyIdle();
    endtask

    task automatic test_misaligned();
        int reqSeen = 0;
        logic        rds [3] = '{1'b1, 1'b1, 1'b1};
        logic        wrs [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  ops [3] = '{3'b010, 3'b010, 3'b110};
        logic [31:0] adr [3] = '{32'h0000_0101, 32'h0000_0000, 32'h0000_0000};
        for (int i = 0; i < 3; i++) begin
            tick();
            applyStimulus(rds[i], wrs[i], ops[i], adr[i], 32'h0);
            settle();
            reqSeen += int'(bus_req_o);
            testsRun++; if (stall_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL err_stall_start_%0d got %0b want 1", i, stall_o); end
            tick(); settle();
            reqSeen += int'(bus_req_o);
            testsRun++; if (err_o !== 1'b1 || stall_o !== 1'b0 || done_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL err_pulse_%0d got err=%0b stall=%0b done=%0b want 1/0/0", i, err_o, stall_o, done_o); end
            tick();
            applyIdle();
            settle();
            reqSeen += int'(bus_req_o);
            testsRun++; if (err_o !== 1'b0 || stall_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL err_after_%0d got err=%0b stall=%0b want 0/0", i, err_o, stall_o); end
        end
        testsRun++; if (reqSeen !== 0) begin testsFailed++; $display("[TB] FAIL err_no_bus got %0d req cycles want 0", reqSeen); end
    endtask

    task automatic test_timeout();
        int reqCount = 0, errCount = 0, doneCount = 0;
        tick();
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0);
        for (int c = 0; c < 8; c++) begin
            tick(); settle();
            reqCount  += int'(bus_req_o);
            errCount  += int'(err_o);
            doneCount += int'(done_o);
            if (err_o) applyIdle();
        end
        testsRun++; if (reqCount !== 4) begin testsFailed++; $display("[TB] FAIL to_req_cycles got %0d want 4", reqCount); end
        testsRun++; if (errCount !== 1 || doneCount !== 0) begin testsFailed++; $display("[TB] FAIL to_err_done got err=%0d done=%0d want 1/0", errCount, doneCount); end
        applyStimulus(1'b0, 1'b1, 3'b111, 32'h0000_0044, 32'hCAFE_F00D);
        tick();
        bus_ack_i = 1'b1;
        settle();
        testsRun++; if (bus_wdata_o !== 32'hCAFE_F00D || bus_be_o !== 4'b1111 || bus_addr_o !== 32'h0000_0044) begin testsFailed++; $display("[TB] FAIL to_sw_bus got %h/%b/%h want cafef00d/1111/00000044", bus_wdata_o, bus_be_o, bus_addr_o); end
        tick();
        bus_ack_i = 1'b0;
        settle();
        testsRun++; if (done_o !== 1'b1 || err_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL to_sw_done got done=%0b err=%0b want 1/0", done_o, err_o); end
        tick();
        applyIdle();
    endtask

    task automatic test_reset_mid();
        tick();
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0080, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        applyIdle();
        tick();
        rst = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h1234_5678;
        settle();
        testsRun++; if (bus_req_o !== 1'b0 || stall_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_mid_ctl got req=%0b stall=%0b done=%0b err=%0b want 0", bus_req_o, stall_o, done_o, err_o); end
        testsRun++; if (bus_addr_o !== 32'h0 || bus_be_o !== 4'h0 || rdata_o !== 32'h0) begin testsFailed++; $display("[TB] FAIL rst_mid_data got %h/%b/%h want 0", bus_addr_o, bus_be_o, rdata_o); end
        tick();
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        settle();
        testsRun++; if (done_o !== 1'b0 || rdata_o !== 32'h0 || bus_req_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_late_ack got done=%0b rdata=%h req=%0b want 0", done_o, rdata_o, bus_req_o); end
    endtask

    task automatic test_back_to_back();
        tick();
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0);
        tick();
        bus_ack_i = 1'b1; bus_rdata_i = 32'h1122_3344;
        tick();
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        settle();
        testsRun++; if (done_o !== 1'b1 || rdata_o !== 32'h1122_3344) begin testsFailed++; $display("[TB] FAIL b2b_lw got done=%0b rdata=%h want 1/11223344", done_o, rdata_o); end
        tick();
        applyStimulus(1'b0, 1'b1, 3'b111, 32'h0000_0014, 32'h5566_7788);
        settle();
        testsRun++; if (stall_o !== 1'b1 || bus_req_o !== 1'b0 || done_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_bubble got stall=%0b req=%0b done=%0b want 1/0/0", stall_o, bus_req_o, done_o); end
        testsRun++; if (rdata_o !== 32'h1122_3344) begin testsFailed++; $display("[TB] FAIL b2b_rdata_hold got %h want 11223344", rdata_o); end
        tick();
        bus_ack_i = 1'b1;
        settle();
        testsRun++; if (bus_req_o !== 1'b1 || bus_we_o !== 1'b1 || bus_addr_o !== 32'h0000_0014 || bus_wdata_o !== 32'h5566_7788) begin testsFailed++; $display("[TB] FAIL b2b_sw_bus got req=%0b we=%0b addr=%h wd=%h", bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o); end
        tick();
        bus_ack_i = 1'b0;
        settle();
        testsRun++; if (done_o !== 1'b1 || rdata_o !== 32'h0) begin testsFailed++; $display("[TB] FAIL b2b_sw_done got done=%0b rdata=%h want 1/0", done_o, rdata_o); end
        tick();
        applyIdle();
    endtask

    initial begin
        test_reset();
        test_lw_basic();
        test_byte_loads();
        test_store_half();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
